// File: rtl/serial_link_pwr_seq.sv
// Power-state sequencer for one serial link: clock gate, link reset and AXI isolation in a fixed, handshaked order.
// Define SERIAL_LINK_PWR_SEQ_TIMEOUT_EN to add the isolation-handshake timeout and the sticky err_o flag.
module serial_link_pwr_seq #(
   parameter int ClkSettleCycles = 8,
   parameter int RstCycles       = 16,
   parameter int TimeoutCycles   = 1024
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       link_en_i,
   input  logic [1:0] isolated_i,
   input  logic       err_clr_i,
   output logic       clk_ena_o,
   output logic       reset_no,
   output logic [1:0] isolate_o,
   output logic       link_up_o,
   output logic       busy_o,
   output logic       err_o,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      S_OFF        = 3'd0,
      S_CLK_ON     = 3'd1,
      S_RST_REL    = 3'd2,
      S_DEISO      = 3'd3,
      S_ON         = 3'd4,
      S_ISO        = 3'd5,
      S_RST_ASSERT = 3'd6,
      S_CLK_OFF    = 3'd7
   } state_t;

   localparam int MaxSeq = (ClkSettleCycles > RstCycles) ? ClkSettleCycles : RstCycles;
`ifdef SERIAL_LINK_PWR_SEQ_TIMEOUT_EN
   localparam int MaxCnt = (TimeoutCycles > MaxSeq) ? TimeoutCycles : MaxSeq;
`else
   localparam int MaxCnt = MaxSeq;
`endif
   localparam int CntW = $clog2(MaxCnt + 1);

   localparam logic [CntW-1:0] LdClk = CntW'(ClkSettleCycles - 1);
   localparam logic [CntW-1:0] LdRst = CntW'(RstCycles - 1);
`ifdef SERIAL_LINK_PWR_SEQ_TIMEOUT_EN
   localparam logic [CntW-1:0] LdTo  = CntW'(TimeoutCycles - 1);
`endif

   state_t            r_state;
   logic [CntW-1:0]   r_cnt;
   logic              r_clk_ena;
   logic              r_reset_n;
   logic [1:0]        r_isolate;
   logic              r_link_up;
   logic              r_busy;

   state_t            w_state_nxt;
   logic [CntW-1:0]   w_cnt_nxt;
   logic              w_clk_ena;
   logic              w_reset_n;
   logic [1:0]        w_isolate;
`ifdef SERIAL_LINK_PWR_SEQ_TIMEOUT_EN
   logic              w_timeout;
   logic              r_err;
`endif

   // NOTE: every always_comb output gets a default before the case, so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
`ifdef SERIAL_LINK_PWR_SEQ_TIMEOUT_EN
      w_timeout   = 1'b0;
`endif
      case (r_state)
         S_OFF:        if (link_en_i) w_state_nxt = S_CLK_ON;
         S_CLK_ON:     if (r_cnt == '0) w_state_nxt = S_RST_REL;
         S_RST_REL:    w_state_nxt = S_DEISO;
         S_DEISO: begin
            if (isolated_i == 2'b00) w_state_nxt = S_ON;
`ifdef SERIAL_LINK_PWR_SEQ_TIMEOUT_EN
            else if (r_cnt == '0) begin
               w_timeout   = 1'b1;
               w_state_nxt = S_ISO;
            end
`endif
         end
         S_ON:         if (!link_en_i) w_state_nxt = S_ISO;
         S_ISO: begin
            if (isolated_i == 2'b11) w_state_nxt = S_RST_ASSERT;
`ifdef SERIAL_LINK_PWR_SEQ_TIMEOUT_EN
            // Forced tear-down: a stuck isolator must not keep the link powered.
            else if (r_cnt == '0) begin
               w_timeout   = 1'b1;
               w_state_nxt = S_RST_ASSERT;
            end
`endif
         end
         S_RST_ASSERT: if (r_cnt == '0) w_state_nxt = S_CLK_OFF;
         S_CLK_OFF:    w_state_nxt = S_OFF;
         default:      w_state_nxt = S_OFF;
      endcase
   end

   always_comb begin
      w_cnt_nxt = (r_cnt == '0) ? '0 : r_cnt - CntW'(1);
      if (w_state_nxt != r_state) begin
         case (w_state_nxt)
            S_CLK_ON:     w_cnt_nxt = LdClk;
            S_RST_ASSERT: w_cnt_nxt = LdRst;
`ifdef SERIAL_LINK_PWR_SEQ_TIMEOUT_EN
            S_DEISO,
            S_ISO:        w_cnt_nxt = LdTo;
`endif
            default:      w_cnt_nxt = '0;
         endcase
      end
   end

   // Outputs are decoded from the next state and registered, so they line up with state_o.
   always_comb begin
      w_clk_ena = 1'b1;
      w_reset_n = 1'b1;
      w_isolate = 2'b11;
      case (w_state_nxt)
         S_OFF: begin
            w_clk_ena = 1'b0;
            w_reset_n = 1'b0;
         end
         S_CLK_ON:     w_reset_n = 1'b0;
         S_DEISO,
         S_ON:         w_isolate = 2'b00;
         S_RST_ASSERT: w_reset_n = 1'b0;
         S_CLK_OFF: begin
            w_clk_ena = 1'b0;
            w_reset_n = 1'b0;
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= S_OFF;
         r_cnt     <= '0;
         r_clk_ena <= 1'b0;
         r_reset_n <= 1'b0;
         r_isolate <= 2'b11;
         r_link_up <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_clk_ena <= w_clk_ena;
         r_reset_n <= w_reset_n;
         r_isolate <= w_isolate;
         r_link_up <= (w_state_nxt == S_ON);
         r_busy    <= (w_state_nxt != S_OFF) && (w_state_nxt != S_ON);
      end
   end

`ifdef SERIAL_LINK_PWR_SEQ_TIMEOUT_EN
   // Set has priority over a coincident clear.
   always_ff @(posedge clk_i) begin
      if (rst_i)          r_err <= 1'b0;
      else if (w_timeout) r_err <= 1'b1;
      else if (err_clr_i) r_err <= 1'b0;
   end
   assign err_o = r_err;
`else
   logic w_unused;
   assign w_unused = err_clr_i & (TimeoutCycles > 0);
   assign err_o    = 1'b0;
`endif

   assign clk_ena_o = r_clk_ena;
   assign reset_no  = r_reset_n;
   assign isolate_o = r_isolate;
   assign link_up_o = r_link_up;
   assign busy_o    = r_busy;
   assign state_o   = r_state;

endmodule

// File: tb/tb_serial_link_pwr_seq.sv
// Scoreboard bench for serial_link_pwr_seq: a time-in-state reference model predicts every output cycle.
// Expectations follow SERIAL_LINK_PWR_SEQ_TIMEOUT_EN the same way the design does.
module tb_serial_link_pwr_seq;

   localparam int CLK_SETTLE = 8;
   localparam int RST_CYC    = 16;
   localparam int TIMEOUT    = 4;
`ifdef SERIAL_LINK_PWR_SEQ_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   localparam int ST_OFF = 0, ST_CLK_ON = 1, ST_RST_REL = 2, ST_DEISO = 3;
   localparam int ST_ON = 4, ST_ISO = 5, ST_RST_ASSERT = 6, ST_CLK_OFF = 7;

   typedef struct packed {
      logic       clk;
      logic       rstn;
      logic [1:0] iso;
      logic       up;
      logic       busy;
      logic       err;
      logic [2:0] st;
   } exp_t;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       link_en_i = 1'b0;
   logic [1:0] isolated_i = 2'b11;
   logic       err_clr_i = 1'b0;
   logic       clk_ena_o, reset_no, link_up_o, busy_o, err_o;
   logic [1:0] isolate_o;
   logic [2:0] state_o;

   serial_link_pwr_seq #(
      .ClkSettleCycles(CLK_SETTLE),
      .RstCycles      (RST_CYC),
      .TimeoutCycles  (TIMEOUT)
   ) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .link_en_i (link_en_i),
      .isolated_i(isolated_i),
      .err_clr_i (err_clr_i),
      .clk_ena_o (clk_ena_o),
      .reset_no  (reset_no),
      .isolate_o (isolate_o),
      .link_up_o (link_up_o),
      .busy_o    (busy_o),
      .err_o     (err_o),
      .state_o   (state_o)
   );

   always #5 clk_i = ~clk_i;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   exp_t sb_q[$];

   // Reference model: state number, cycles spent in it so far, sticky error.
   int   m_st  = ST_OFF;
   int   m_cnt = 0;
   bit   m_err = 1'b0;

   // Isolation environment: follow isolate_o two cycles late, or hold a forced value.
   bit         iso_follow = 1'b1;
   logic [1:0] iso_force  = 2'b11;
   logic [1:0] d1 = 2'b11, d2 = 2'b11;
   bit         up_seen = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic exp_t model_out();
      exp_t e;
      e.st   = 3'(m_st);
      e.err  = m_err;
      e.up   = (m_st == ST_ON);
      e.busy = !(m_st == ST_OFF || m_st == ST_ON);
      case (m_st)
         ST_OFF:        {e.clk, e.rstn, e.iso} = 4'b0011;
         ST_CLK_ON:     {e.clk, e.rstn, e.iso} = 4'b1011;
         ST_RST_REL:    {e.clk, e.rstn, e.iso} = 4'b1111;
         ST_DEISO:      {e.clk, e.rstn, e.iso} = 4'b1100;
         ST_ON:         {e.clk, e.rstn, e.iso} = 4'b1100;
         ST_ISO:        {e.clk, e.rstn, e.iso} = 4'b1111;
         ST_RST_ASSERT: {e.clk, e.rstn, e.iso} = 4'b1011;
         default:       {e.clk, e.rstn, e.iso} = 4'b0011;
      endcase
      return e;
   endfunction

   task automatic model_step(input bit rst, input bit en, input logic [1:0] iso, input bit clr);
      int nxt;
      bit to;
      nxt = m_st;
      to  = 1'b0;
      if (rst) begin
         m_st  = ST_OFF;
         m_cnt = 0;
         m_err = 1'b0;
         return;
      end
      case (m_st)
         ST_OFF:        if (en) nxt = ST_CLK_ON;
         ST_CLK_ON:     if (m_cnt == CLK_SETTLE - 1) nxt = ST_RST_REL;
         ST_RST_REL:    nxt = ST_DEISO;
         ST_DEISO: begin
            if (iso == 2'b00) nxt = ST_ON;
            else if (TO_EN && m_cnt == TIMEOUT - 1) begin to = 1'b1; nxt = ST_ISO; end
         end
         ST_ON:         if (!en) nxt = ST_ISO;
         ST_ISO: begin
            if (iso == 2'b11) nxt = ST_RST_ASSERT;
            else if (TO_EN && m_cnt == TIMEOUT - 1) begin to = 1'b1; nxt = ST_RST_ASSERT; end
         end
         ST_RST_ASSERT: if (m_cnt == RST_CYC - 1) nxt = ST_CLK_OFF;
         default:       nxt = ST_OFF;
      endcase
      if (TO_EN) begin
         if (to)       m_err = 1'b1;
         else if (clr) m_err = 1'b0;
      end
      if (nxt != m_st) begin
         m_st  = nxt;
         m_cnt = 0;
      end else begin
         m_cnt++;
      end
   endtask

   // One cycle of stimulus; on return the DUT outputs show this cycle's values.
   task automatic tick(input bit rst, input bit en, input bit clr);
      logic [1:0] iso_v;
      @(negedge clk_i);
      cyc++;
      if (link_up_o) up_seen = 1'b1;
      iso_v = iso_follow ? d2 : iso_force;
      d2 = d1;
      d1 = isolate_o;
      rst_i      = rst;
      link_en_i  = en;
      err_clr_i  = clr;
      isolated_i = iso_v;
      model_step(rst, en, iso_v, clr);
      sb_q.push_back(model_out());
   endtask

   task automatic run(input int n, input bit en);
      repeat (n) tick(1'b0, en, 1'b0);
   endtask

   task automatic bring_up();
      iso_follow = 1'b1;
      run(16, 1'b1);
      check("bring_up_on", state_o, ST_ON);
   endtask

   task automatic tear_down();
      iso_follow = 1'b1;
      run(30, 1'b0);
      check("tear_down_off", state_o, ST_OFF);
   endtask

   // Monitor: every cycle after the edge, compare the oldest prediction.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk_i);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_outputs", {clk_ena_o, reset_no, isolate_o, link_up_o, busy_o, err_o, state_o}, e);
         end
      end
   end

   initial begin
      bit en_r;
      repeat (3) tick(1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      check("reset_vals", {clk_ena_o, reset_no, isolate_o, link_up_o, busy_o, err_o, state_o}, 10'b00_11_000_000);

      // Bring-up with isolated_i following isolate_o two cycles late.
      iso_follow = 1'b1;
      tick(1'b0, 1'b1, 1'b0);                         // cycle 0
      run(1, 1'b1);
      check("up_clk_ena_c1", {clk_ena_o, reset_no}, 2'b10);
      run(7, 1'b1);
      check("up_rst_held_c8", reset_no, 1'b0);
      run(1, 1'b1);
      check("up_rst_rel_c9", {reset_no, isolate_o}, 3'b111);
      run(1, 1'b1);
      check("up_deiso_c10", isolate_o, 2'b00);
      run(2, 1'b1);
      check("up_not_yet_c12", link_up_o, 1'b0);
      run(1, 1'b1);
      check("up_link_up_c13", {link_up_o, busy_o}, 2'b10);
      run(3, 1'b1);

      // Tear-down from ON.
      tick(1'b0, 1'b0, 1'b0);                         // cycle 0
      run(1, 1'b0);
      check("dn_iso_c1", {isolate_o, state_o}, {2'b11, 3'(ST_ISO)});
      run(2, 1'b0);
      check("dn_rst_held_c3", reset_no, 1'b1);
      run(1, 1'b0);
      check("dn_rst_assert_c4", reset_no, 1'b0);
      run(15, 1'b0);
      check("dn_clk_still_c19", clk_ena_o, 1'b1);
      run(1, 1'b0);
      check("dn_clk_off_c20", {clk_ena_o, state_o}, {1'b0, 3'(ST_CLK_OFF)});
      run(1, 1'b0);
      check("dn_off_c21", state_o, ST_OFF);
      run(3, 1'b0);

      // Partial isolation stuck at 01 during ISO.
      bring_up();
      iso_follow = 1'b0;
      iso_force  = 2'b01;
      tick(1'b0, 1'b0, 1'b0);                         // cycle 0
`ifdef SERIAL_LINK_PWR_SEQ_TIMEOUT_EN
      run(4, 1'b0);
      check("part_wait_c4", {err_o, state_o}, {1'b0, 3'(ST_ISO)});
      run(1, 1'b0);
      check("part_timeout_c5", {err_o, state_o}, {1'b1, 3'(ST_RST_ASSERT)});
      tick(1'b0, 1'b0, 1'b1);
      check("part_err_sticky", err_o, 1'b1);
      tick(1'b0, 1'b0, 1'b0);
      check("part_err_clr", err_o, 1'b0);
`else
      run(10, 1'b0);
      check("part_wait_forever", {err_o, state_o}, {1'b0, 3'(ST_ISO)});
      tick(1'b0, 1'b0, 1'b1);
`endif
      tear_down();

      // DEISO with isolated_i stuck at 11.
      iso_follow = 1'b0;
      iso_force  = 2'b11;
      up_seen    = 1'b0;
      tick(1'b0, 1'b1, 1'b0);                         // cycle 0
`ifdef SERIAL_LINK_PWR_SEQ_TIMEOUT_EN
      run(13, 1'b0);
      check("deiso_wait_c13", {err_o, state_o}, {1'b0, 3'(ST_DEISO)});
      run(1, 1'b0);
      check("deiso_timeout_c14", {err_o, state_o}, {1'b1, 3'(ST_ISO)});
      run(1, 1'b0);
      check("deiso_rst_c15", state_o, ST_RST_ASSERT);
      run(17, 1'b0);
      check("deiso_off_c32", state_o, ST_OFF);
      check("deiso_never_up", up_seen, 1'b0);
      tick(1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b0);
      check("deiso_err_clr", err_o, 1'b0);
`else
      run(20, 1'b0);
      check("deiso_wait_forever", {link_up_o, state_o}, {1'b0, 3'(ST_DEISO)});
      check("deiso_never_up", up_seen, 1'b0);
      tear_down();
`endif

      // One-cycle request pulse: bring-up completes, then tears down at once.
      iso_follow = 1'b1;
      tick(1'b0, 1'b1, 1'b0);                         // cycle 0
      run(13, 1'b0);
      check("pulse_on_c13", {link_up_o, state_o}, {1'b1, 3'(ST_ON)});
      run(1, 1'b0);
      check("pulse_iso_c14", state_o, ST_ISO);
      tear_down();

      // Synchronous reset while in DEISO.
      tick(1'b0, 1'b1, 1'b0);                         // cycle 0
      run(9, 1'b1);
      tick(1'b1, 1'b1, 1'b0);                         // cycle 10, reset driven
      check("rst_in_deiso_c10", state_o, ST_DEISO);
      tick(1'b0, 1'b0, 1'b0);
      check("rst_vals_c11", {clk_ena_o, reset_no, isolate_o, link_up_o, busy_o, err_o, state_o}, 10'b00_11_000_000);
      run(3, 1'b0);

      // Randomised traffic against the model.
      en_r = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 39) == 0) en_r = ~en_r;
         if (i % 60 == 0) begin
            if ($urandom_range(0, 3) == 0) begin
               iso_follow = 1'b0;
               iso_force  = 2'($urandom_range(0, 3));
            end else begin
               iso_follow = 1'b1;
            end
         end
         tick(($urandom_range(0, 299) == 0), en_r, ($urandom_range(0, 15) == 0));
      end

      @(posedge clk_i);
      #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
